sipo_deserializer: RTL and testbench

SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

---
 rtl/serial_pkg.sv | 12 +
 rtl/mod_n_counter.sv | 28 ++
 rtl/sipo_deserializer.sv | 96 +++++++++
 tb/tb_sipo_deserializer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial deserializer: default word width and
// one-hot assembly FSM state encodings.
package serial_pkg;

  localparam int DEFAULT_N = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'b01,
    SHIFT = 2'b10
  } state_t;

endpackage

// File: rtl/mod_n_counter.sv
// Wrapping modulo-MOD counter with synchronous clear and a terminal-count
// flag that is high while the count sits at MOD-1.
module mod_n_counter #(
  parameter int MOD = 6,
  parameter int W   = $clog2(MOD)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic tc
);

  logic [W-1:0] count;

  assign tc = (count == W'(MOD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tc ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// LSB-first serial-to-parallel deserializer with a one-word output buffer,
// valid/ready drain and a sticky overrun flag for dropped words.
module sipo_deserializer
  import serial_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic         serial_in,
  input  logic         clear,
  input  logic         out_ready,
  output logic [N-1:0] parallel_out,
  output logic         out_valid,
  output logic         overrun,
  output logic         busy
);

  state_t       state, state_nxt;
  // Only the N-1 bits that survive into the next shift are stored; the
  // oldest bit always falls off the bottom.
  logic [N-2:0] sr;
  logic [N-1:0] word_nxt;
  logic         accept;
  logic         tc;
  logic         complete;

  assign accept   = enable & ~clear;
  assign word_nxt = {serial_in, sr};
  assign complete = accept & tc;
  assign busy     = (state == SHIFT);

  mod_n_counter #(
    .MOD (N)
  ) u_bit_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (accept),
    .clear  (clear),
    .tc     (tc)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)   state_nxt = SHIFT;
      SHIFT:   if (complete) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (clear) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (clear) begin
      sr <= '0;
    end else if (accept) begin
      sr <= word_nxt[N-1:1];
    end
  end

  // A completing word lands in the buffer if it is empty or draining now;
  // otherwise it is dropped and overrun latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parallel_out <= '0;
      out_valid    <= 1'b0;
      overrun      <= 1'b0;
    end else if (clear) begin
      parallel_out <= '0;
      out_valid    <= 1'b0;
      overrun      <= 1'b0;
    end else if (complete) begin
      if (!out_valid || out_ready) begin
        parallel_out <= word_nxt;
        out_valid    <= 1'b1;
      end else begin
        overrun      <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Scoreboard bench for sipo_deserializer: a bit-queue reference model
// predicts words and flags; a monitor pops expected words on each handshake.
module tb_sipo_deserializer;

  localparam int N = 6;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic         serial_in;
  logic         clear;
  logic         out_ready;
  logic [N-1:0] parallel_out;
  logic         out_valid;
  logic         overrun;
  logic         busy;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit           bits[$];
  logic [N-1:0] sb[$];
  bit           mdl_valid;
  bit           mdl_ovr;
  logic [N-1:0] mdl_po;

  sipo_deserializer #(.N(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .serial_in    (serial_in),
    .clear        (clear),
    .out_ready    (out_ready),
    .parallel_out (parallel_out),
    .out_valid    (out_valid),
    .overrun      (overrun),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    bits.delete();
    sb.delete();
    mdl_valid = 0;
    mdl_ovr   = 0;
    mdl_po    = '0;
  endtask

  // Predict the effect of the coming rising edge from the buffer rules.
  task automatic model_step(input logic en, input logic b, input logic rdy, input logic clr);
    bit           drain;
    logic [N-1:0] w;
    if (clr) begin
      model_reset();
    end else begin
      drain = mdl_valid && rdy;
      if (en) bits.push_back(b);
      if (bits.size() == N) begin
        w = '0;
        for (int i = 0; i < N; i++) if (bits[i]) w = w + (N'(1) << i);
        bits.delete();
        if (!mdl_valid || rdy) begin
          sb.push_back(w);
          mdl_po    = w;
          mdl_valid = 1;
        end else begin
          mdl_ovr = 1;
        end
      end else if (drain) begin
        mdl_valid = 0;
      end
    end
  endtask

  task automatic check_state();
    chk("out_valid",    int'(out_valid),    int'(mdl_valid));
    chk("overrun",      int'(overrun),      int'(mdl_ovr));
    chk("busy",         int'(busy),         int'(bits.size() > 0));
    chk("parallel_out", int'(parallel_out), int'(mdl_po));
  endtask

  // Entered and left at posedge+1: drive inputs, predict, clock, compare.
  task automatic cycle(input logic en, input logic b, input logic rdy, input logic clr);
    enable    = en;
    serial_in = b;
    out_ready = rdy;
    clear     = clr;
    model_step(en, b, rdy, clr);
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic send_word(input logic [N-1:0] w, input logic rdy,
                           input logic rdy_last, input int maxgap);
    for (int i = 0; i < N; i++) begin
      if (i > 0 && maxgap > 0) begin
        int gaps = $urandom_range(maxgap, 1);
        for (int g = 0; g < gaps; g++) cycle(1'b0, 1'($urandom % 2), rdy, 1'b0);
      end
      cycle(1'b1, w[i], (i == N - 1) ? rdy_last : rdy, 1'b0);
    end
  endtask

  // Monitor: every handshake consumes the oldest predicted word.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && !clear && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_word", int'(parallel_out), -1);
        end else begin
          chk("sb_word", int'(parallel_out), int'(sb.pop_front()));
        end
      end
    end
  end

  initial begin
    logic [N-1:0] w;
    rst_n     = 1'b0;
    enable    = 1'b0;
    serial_in = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_po",    int'(parallel_out), 0);
    chk("reset_valid", int'(out_valid),    0);
    chk("reset_ovr",   int'(overrun),      0);
    chk("reset_busy",  int'(busy),         0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back word, always ready.
    send_word(6'b101101, 1'b1, 1'b1, 0);
    chk("b2b_valid", int'(out_valid), 1);
    chk("b2b_word",  int'(parallel_out), int'(6'b101101));
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("b2b_drained", int'(out_valid), 0);

    // Same word with idle gaps between bits.
    send_word(6'b101101, 1'b1, 1'b1, 3);
    chk("gap_word", int'(parallel_out), int'(6'b101101));
    cycle(1'b0, 1'b0, 1'b1, 1'b0);

    // Overrun: second word dropped while first is held.
    send_word(6'h15, 1'b0, 1'b0, 0);
    send_word(6'h2A, 1'b0, 1'b0, 0);
    chk("ovr_word",  int'(parallel_out), int'(6'h15));
    chk("ovr_valid", int'(out_valid), 1);
    chk("ovr_flag",  int'(overrun), 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // Drain coincides with completion: new word replaces, no overrun.
    send_word(6'h15, 1'b0, 1'b0, 0);
    send_word(6'h2A, 1'b0, 1'b1, 0);
    chk("swap_valid", int'(out_valid), 1);
    chk("swap_word",  int'(parallel_out), int'(6'h2A));
    chk("swap_ovr",   int'(overrun), 0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset mid-word, with a pending word and overrun set.
    send_word(6'h3C, 1'b0, 1'b0, 0);
    send_word(6'h01, 1'b0, 1'b0, 0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    enable = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_po",    int'(parallel_out), 0);
    chk("arst_valid", int'(out_valid),    0);
    chk("arst_ovr",   int'(overrun),      0);
    chk("arst_busy",  int'(busy),         0);
    model_reset();
    #1 rst_n = 1'b1;
    send_word(6'h2A, 1'b1, 1'b1, 0);
    chk("arst_new_word", int'(parallel_out), int'(6'h2A));
    cycle(1'b0, 1'b0, 1'b1, 1'b0);

    // Clear mid-word with overrun set; its serial bit is discarded.
    send_word(6'h0F, 1'b0, 1'b0, 0);
    send_word(6'h30, 1'b0, 1'b0, 0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'($urandom % 2), 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    chk("clr_busy",  int'(busy), 0);
    chk("clr_ovr",   int'(overrun), 0);
    chk("clr_valid", int'(out_valid), 0);
    chk("clr_po",    int'(parallel_out), 0);
    send_word(6'h27, 1'b1, 1'b1, 0);
    chk("clr_new_word", int'(parallel_out), int'(6'h27));

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      cycle(1'($urandom_range(99) < 70), 1'($urandom % 2),
            1'($urandom_range(99) < 60), 1'($urandom_range(99) < 2));
    end
    for (int c = 0; c < 4; c++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
